// File: rtl/mmio_bus_bridge.sv
// Registered MMIO bridge: decodes the core's data-port address into one of N_SLV slave
// windows, runs a req/ready handshake with timeout, and logs faulting accesses.
module mmio_bus_bridge #(
  parameter int unsigned           N_SLV    = 3,
  parameter logic [N_SLV*32-1:0]   SLV_BASE = {32'h00004004, 32'h00004000, 32'h00000000},
  parameter logic [N_SLV*32-1:0]   SLV_MASK = {32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFC000},
  parameter int unsigned           TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_err,
  output logic [N_SLV-1:0]      slv_sel,
  output logic                  slv_we,
  output logic [31:0]           slv_addr,
  output logic [31:0]           slv_wdata,
  input  logic [N_SLV*32-1:0]   slv_rdata,
  input  logic [N_SLV-1:0]      slv_ready,
  output logic [31:0]           err_addr,
  output logic [7:0]            err_cnt
);

  localparam int unsigned CntW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TimeoutEn = (TIMEOUT != 0);
  localparam logic [CntW-1:0] TmoVal = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q;
  logic [CntW-1:0]   wait_cnt_q;

  logic [N_SLV-1:0]  hit_vec;
  logic [N_SLV-1:0]  hit_oh;
  logic              any_hit;
  logic              sel_ready;
  logic [31:0]       sel_rdata;
  logic [7:0]        err_cnt_inc;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < N_SLV; i++) begin
      hit_vec[i] = ((cpu_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]);
    end
  end

  // Isolate the lowest set bit so overlapping windows resolve to the lowest slot.
  assign hit_oh  = hit_vec & (~hit_vec + N_SLV'(1));
  assign any_hit = |hit_vec;

  assign sel_ready = |(slv_sel & slv_ready);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (slv_sel[i]) begin
        sel_rdata = sel_rdata | slv_rdata[32*i +: 32];
      end
    end
  end

  assign err_cnt_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      slv_sel    <= '0;
      slv_we     <= 1'b0;
      slv_addr   <= '0;
      slv_wdata  <= '0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      cpu_err    <= 1'b0;
      err_addr   <= '0;
      err_cnt    <= '0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cpu_req) begin
            slv_addr  <= cpu_addr;
            slv_we    <= cpu_we;
            slv_wdata <= cpu_wdata;
            if (any_hit) begin
              slv_sel    <= hit_oh;
              wait_cnt_q <= '0;
              state_q    <= StAccess;
            end else begin
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
              err_addr  <= cpu_addr;
              err_cnt   <= err_cnt_inc;
              state_q   <= StResp;
            end
          end
        end
        StAccess: begin
          // Ready beats timeout when both land in the same cycle.
          if (sel_ready) begin
            slv_sel   <= '0;
            cpu_ready <= 1'b1;
            cpu_rdata <= slv_we ? 32'h0 : sel_rdata;
            state_q   <= StResp;
          end else if (TimeoutEn && (wait_cnt_q == TmoVal)) begin
            slv_sel   <= '0;
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= '0;
            err_addr  <= slv_addr;
            err_cnt   <= err_cnt_inc;
            state_q   <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
